// File: rtl/me_plane_ctrl_pkg.sv
// rtl/me_plane_ctrl_pkg.sv - shared state encodings, screen/plane geometry and helpers for the player plane
//
// Purpose: the FSM state encoding, the screen and sprite dimensions, the spawn point and the
// counter-width helper used by me_plane_ctrl and its debouncer.
// Ports: none (package).

package me_plane_ctrl_pkg;

  typedef enum logic [1:0] {
    ME_IDLE   = 2'd0,
    ME_ALIVE  = 2'd1,
    ME_INVINC = 2'd2,
    ME_OVER   = 2'd3
  } me_state_t;

  localparam int ME_H_DISP     = 640;
  localparam int ME_V_DISP     = 480;
  localparam int ME_PLANE_W    = 102;
  localparam int ME_PLANE_H    = 126;
  localparam int ME_X_INIT     = 269;
  localparam int ME_Y_INIT     = 354;
  localparam int ME_LIVES_INIT = 3;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/me_plane_ctrl_btn_debounce.sv
// rtl/me_plane_ctrl_btn_debounce.sv - 2-FF synchroniser plus level debouncer for one button
//
// Purpose: brings a raw asynchronous button into clk_run and accepts a new level only after
// the synchronised input has disagreed with the current level for DEB_CYCLES consecutive cycles.
// A clean raw edge reaches the output DEB_CYCLES+2 cycles later.
// Ports:
//   clk_run  in   run clock
//   rst      in   asynchronous active-high reset
//   raw      in   raw button, active-high
//   level    out  debounced level

module me_plane_ctrl_btn_debounce
  import me_plane_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 2500000
) (
  input  logic clk_run,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle where the input agrees with the accepted level restarts the count,
      // so a glitch shorter than DEB_CYCLES never flips the output.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/me_plane_ctrl.sv
// rtl/me_plane_ctrl.sv - player plane movement, lives and post-hit invincibility controller
//
// Purpose: debounces the four direction buttons, moves the plane STEP pixels per move tick
// clamped to the visible screen, counts lives and runs the IDLE/ALIVE/INVINC/OVER FSM with a
// blinking sprite mask while invincible. All outputs are registered.
// Ports:
//   clk_run       in   run clock
//   rst           in   asynchronous active-high reset
//   game_en_i     in   1 = game running; 0 returns to IDLE with position/lives reinitialised
//   btn_*_i       in   raw direction buttons, active-high
//   crash_me_i    in   1-cycle pulse, enemy overlapped the player
//   me_x_pos_o    out  plane top-left x
//   me_y_pos_o    out  plane top-left y
//   lives_o       out  remaining lives
//   invincible_o  out  1 while hits are ignored
//   blink_o       out  sprite visibility mask (1 = draw)
//   game_over_o   out  1 in OVER

module me_plane_ctrl
  import me_plane_ctrl_pkg::*;
#(
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int H_DISP        = ME_H_DISP,
  parameter int V_DISP        = ME_V_DISP,
  parameter int PLANE_W       = ME_PLANE_W,
  parameter int PLANE_H       = ME_PLANE_H,
  parameter int X_INIT        = ME_X_INIT,
  parameter int Y_INIT        = ME_Y_INIT,
  parameter int STEP          = 1,
  parameter int MOVE_DIV      = 1000000,
  parameter int DEB_CYCLES    = 2500000,
  parameter int LIVES_INIT    = ME_LIVES_INIT,
  parameter int INVINC_CYCLES = 500000000,
  parameter int BLINK_DIV     = 50000000
) (
  input  logic           clk_run,
  input  logic           rst,
  input  logic           game_en_i,
  input  logic           btn_up_i,
  input  logic           btn_down_i,
  input  logic           btn_left_i,
  input  logic           btn_right_i,
  input  logic           crash_me_i,
  output logic [X_W-1:0] me_x_pos_o,
  output logic [Y_W-1:0] me_y_pos_o,
  output logic [1:0]     lives_o,
  output logic           invincible_o,
  output logic           blink_o,
  output logic           game_over_o
);

  localparam int MW = cnt_width(MOVE_DIV);
  localparam int IW = cnt_width(INVINC_CYCLES + 1);
  localparam int BW = cnt_width(BLINK_DIV);

  localparam logic [MW-1:0]  MOVE_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [IW-1:0]  INV_LAST   = IW'(INVINC_CYCLES - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);

  // Clamp arithmetic is one bit wider than the position so x+STEP never wraps.
  localparam logic [X_W:0]   X_STEP  = (X_W + 1)'(STEP);
  localparam logic [X_W:0]   X_MAX   = (X_W + 1)'(H_DISP - PLANE_W);
  localparam logic [Y_W:0]   Y_STEP  = (Y_W + 1)'(STEP);
  localparam logic [Y_W:0]   Y_MAX   = (Y_W + 1)'(V_DISP - PLANE_H);
  localparam logic [X_W-1:0] X_START = X_W'(X_INIT);
  localparam logic [Y_W-1:0] Y_START = Y_W'(Y_INIT);
  localparam logic [1:0]     L_START = 2'(LIVES_INIT);

  logic deb_up;
  logic deb_down;
  logic deb_left;
  logic deb_right;

  me_plane_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_run (clk_run),
    .rst     (rst),
    .raw     (btn_up_i),
    .level   (deb_up)
  );

  me_plane_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk_run (clk_run),
    .rst     (rst),
    .raw     (btn_down_i),
    .level   (deb_down)
  );

  me_plane_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk_run (clk_run),
    .rst     (rst),
    .raw     (btn_left_i),
    .level   (deb_left)
  );

  me_plane_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk_run (clk_run),
    .rst     (rst),
    .raw     (btn_right_i),
    .level   (deb_right)
  );

  me_state_t      state;
  me_state_t      state_nxt;
  logic           invincible_nxt;
  logic           game_over_nxt;

  logic [MW-1:0]  move_cnt;
  logic [IW-1:0]  inv_cnt;
  logic [BW-1:0]  blink_cnt;

  logic           playing;
  logic           tick;
  logic           inv_done;
  logic           hit;

  logic [X_W:0]   x_ext;
  logic [X_W:0]   x_sum;
  logic [X_W:0]   x_mov;
  logic [Y_W:0]   y_ext;
  logic [Y_W:0]   y_sum;
  logic [Y_W:0]   y_mov;

  assign playing  = (state == ME_ALIVE) || (state == ME_INVINC);
  // Gated by playing so a MOVE_DIV of 1 still never ticks in IDLE/OVER.
  assign tick     = playing && (move_cnt == MOVE_LAST);
  assign inv_done = (state == ME_INVINC) && (inv_cnt == INV_LAST);
  assign hit      = (state == ME_ALIVE) && crash_me_i;

  // State register, including the registered state-decoded outputs.
  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      state        <= ME_IDLE;
      invincible_o <= 1'b0;
      game_over_o  <= 1'b0;
    end else begin
      state        <= state_nxt;
      invincible_o <= invincible_nxt;
      game_over_o  <= game_over_nxt;
    end
  end

  // Next-state logic; dropping game_en_i outranks everything, including a crash.
  always_comb begin
    state_nxt = state;
    if (!game_en_i) begin
      state_nxt = ME_IDLE;
    end else begin
      case (state)
        ME_IDLE:   state_nxt = ME_ALIVE;
        ME_ALIVE:  if (crash_me_i) state_nxt = (lives_o > 2'd1) ? ME_INVINC : ME_OVER;
        ME_INVINC: if (inv_done) state_nxt = ME_ALIVE;
        default:   state_nxt = state;
      endcase
    end
  end

  // Output logic, decoded from the next state so the flops line up with the state register.
  always_comb begin
    invincible_nxt = (state_nxt == ME_INVINC);
    game_over_nxt  = (state_nxt == ME_OVER);
  end

  // Per-axis clamped move; pressing both opposite buttons holds that axis.
  always_comb begin
    x_ext = {1'b0, me_x_pos_o};
    x_sum = x_ext + X_STEP;
    x_mov = x_ext;
    if (deb_left && !deb_right) begin
      x_mov = (x_ext < X_STEP) ? '0 : (x_ext - X_STEP);
    end else if (deb_right && !deb_left) begin
      x_mov = (x_sum > X_MAX) ? X_MAX : x_sum;
    end

    y_ext = {1'b0, me_y_pos_o};
    y_sum = y_ext + Y_STEP;
    y_mov = y_ext;
    if (deb_up && !deb_down) begin
      y_mov = (y_ext < Y_STEP) ? '0 : (y_ext - Y_STEP);
    end else if (deb_down && !deb_up) begin
      y_mov = (y_sum > Y_MAX) ? Y_MAX : y_sum;
    end
  end

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      me_x_pos_o <= X_START;
      me_y_pos_o <= Y_START;
      lives_o    <= L_START;
      move_cnt   <= '0;
      inv_cnt    <= '0;
      blink_cnt  <= '0;
      blink_o    <= 1'b1;
    end else if (!game_en_i || (state == ME_IDLE)) begin
      me_x_pos_o <= X_START;
      me_y_pos_o <= Y_START;
      lives_o    <= L_START;
      move_cnt   <= '0;
      inv_cnt    <= '0;
      blink_cnt  <= '0;
      blink_o    <= 1'b1;
    end else begin
      if (!playing || tick) begin
        move_cnt <= '0;
      end else begin
        move_cnt <= move_cnt + 1'b1;
      end

      if (tick) begin
        me_x_pos_o <= X_W'(x_mov);
        me_y_pos_o <= Y_W'(y_mov);
      end

      if (hit) begin
        lives_o <= lives_o - 2'd1;
      end

      // inv_cnt rests at zero outside INVINC, which doubles as the load on entry.
      if (state == ME_INVINC) begin
        inv_cnt <= inv_cnt + 1'b1;
      end else begin
        inv_cnt <= '0;
      end

      if (hit && (lives_o > 2'd1)) begin
        blink_o   <= 1'b0;
        blink_cnt <= '0;
      end else if ((state == ME_INVINC) && !inv_done) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_o   <= ~blink_o;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_o   <= 1'b1;
        blink_cnt <= '0;
      end
    end
  end

endmodule
